// File: rtl/vga_pkg.sv
// vga_pkg: shared SVGA 800x600@56Hz timing defaults and pixel/coordinate types
package vga_pkg;

    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FP     = 24;
    localparam int VGA_H_SYNC   = 72;
    localparam int VGA_H_BP     = 128;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FP     = 1;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 22;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int COORD_W   = 10;
    localparam int COORD_LIM = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t RGB_WHITE = 12'hfff;
    localparam rgb12_t RGB_BLACK = 12'h000;

    function automatic coord_t to_coord(int v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// delay_line: DEPTH-stage register pipeline with synchronous clear; DEPTH = 0 is a wire
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, pixel_clk, rst_n};
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];
            // shift d through DEPTH stages, cleared to inactive on reset
            always_ff @(posedge pixel_clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end
            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: SVGA raster counters, latency-matched sync/blank, registered VGA outputs (optional border: VGA_BORDER_EN)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE      = VGA_H_ACTIVE,
    parameter int   H_FP          = VGA_H_FP,
    parameter int   H_SYNC        = VGA_H_SYNC,
    parameter int   H_BP          = VGA_H_BP,
    parameter int   V_ACTIVE      = VGA_V_ACTIVE,
    parameter int   V_FP          = VGA_V_FP,
    parameter int   V_SYNC        = VGA_V_SYNC,
    parameter int   V_BP          = VGA_V_BP,
    parameter logic SYNC_POL      = 1'b1,
    parameter int   COLOR_LATENCY = 1
) (
    input  logic         pixel_clk,
    input  logic         rst_n,
    output logic [9:0]   h_coord,
    output logic [9:0]   v_coord,
    output logic         display_on,
    output logic         frame_end,
    input  logic [3:0]   red_in,
    input  logic [3:0]   green_in,
    input  logic [3:0]   blue_in,
    output logic [3:0]   vga_r,
    output logic [3:0]   vga_g,
    output logic [3:0]   vga_b,
    output logic         vga_hs,
    output logic         vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > COORD_LIM || V_TOTAL > COORD_LIM) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (COLOR_LATENCY < 0 || COLOR_LATENCY > 4) begin : g_bad_latency
            $error("vga_timing_gen: COLOR_LATENCY must be in 0..4");
        end
    endgenerate

    localparam coord_t H_MAX     = to_coord(H_TOTAL - 1);
    localparam coord_t V_MAX     = to_coord(V_TOTAL - 1);
    localparam coord_t H_ACT     = to_coord(H_ACTIVE);
    localparam coord_t V_ACT     = to_coord(V_ACTIVE);
    localparam coord_t HS_START  = to_coord(H_ACTIVE + H_FP);
    localparam coord_t HS_END    = to_coord(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START  = to_coord(V_ACTIVE + V_FP);
    localparam coord_t VS_END    = to_coord(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t h_cnt, v_cnt;
    logic   h_last, v_last;
    logic   hs_raw, vs_raw;
    logic   hs_d, vs_d, de_d;
    rgb12_t pix_in, pix_sel;

    assign h_last = h_cnt == H_MAX;
    assign v_last = v_cnt == V_MAX;

    // raster counters: h every cycle, v on each line wrap, both wrap at frame end
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 10'd1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        end
    end

    assign h_coord    = h_cnt;
    assign v_coord    = v_cnt;
    assign display_on = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign frame_end  = h_last && v_last;
    assign hs_raw     = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    assign vs_raw     = (v_cnt >= VS_START) && (v_cnt <= VS_END);

    // sync and blank wait COLOR_LATENCY cycles so they meet the returning colour
    delay_line #(.WIDTH(3), .DEPTH(COLOR_LATENCY)) u_sync_dly (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .d         ({hs_raw, vs_raw, display_on}),
        .q         ({hs_d, vs_d, de_d})
    );

    assign pix_in = {red_in, green_in, blue_in};

`ifdef VGA_BORDER_EN
    localparam coord_t H_LAST_ACT = to_coord(H_ACTIVE - 1);
    localparam coord_t V_LAST_ACT = to_coord(V_ACTIVE - 1);
    coord_t h_d, v_d;

    // coordinates follow the same path as sync so the border lands on the right pixel
    delay_line #(.WIDTH(2 * COORD_W), .DEPTH(COLOR_LATENCY)) u_coord_dly (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .d         ({h_cnt, v_cnt}),
        .q         ({h_d, v_d})
    );

    assign pix_sel = (h_d == '0 || h_d == H_LAST_ACT || v_d == '0 || v_d == V_LAST_ACT) ? RGB_WHITE : pix_in;
`else
    assign pix_sel = pix_in;
`endif

    // output register: blank-gated colour and polarity-adjusted syncs
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
        end else begin
            vga_r  <= de_d ? pix_sel.r : RGB_BLACK.r;
            vga_g  <= de_d ? pix_sel.g : RGB_BLACK.g;
            vga_b  <= de_d ? pix_sel.b : RGB_BLACK.b;
            vga_hs <= hs_d ~^ SYNC_POL;
            vga_vs <= vs_d ~^ SYNC_POL;
        end
    end

endmodule
